// File: rtl/mult_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult_rr_arbiter
//   Shares one 4-cycle 8x8 unsigned multiplier between NUM_REQ requesters.
//   Round-robin grant, one operation in flight at a time. A watchdog aborts
//   the operation if the multiplier never answers.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_a/req_b   per-requester request; operands packed 8 bits each
//   req_ready               one-hot accept strobe, only while idle
//   rsp_valid/rsp_ready     per-requester response handshake (one-hot valid)
//   rsp_result              16-bit product, stable while rsp_valid is set
//   mult_start/a/b          multiplier launch (pulse and operands, else 0)
//   mult_done/mult_result   multiplier completion, honoured only in WAIT
//   busy                    any state but IDLE
//   err_timeout/err_id      abort pulse and ID of the aborted requester
// ---------------------------------------------------------------------------
module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [15:0]            rsp_result,
  output logic                   mult_start,
  output logic [7:0]             mult_a,
  output logic [7:0]             mult_b,
  input  logic                   mult_done,
  input  logic [15:0]            mult_result,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [IDW-1:0]         err_id
);

  localparam int DATA_W = 8;
  localparam int CNTW   = $clog2(TIMEOUT + 1);
  localparam logic [IDW-1:0]  PTR_RST  = IDW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur_id;
  logic [CNTW-1:0]  wd_cnt;

  // First set bit of v, searching upward from p+1 and wrapping.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0]     p);
    logic [IDW-1:0] r;
    logic [IDW-1:0] idx;
    logic           found;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(p) + k) % NUM_REQ);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  logic [IDW-1:0] gnt_id;
  logic           grant;
  logic           rsp_hs;

  assign gnt_id = rr_pick(req_valid, ptr);
  assign grant  = (state == S_IDLE) && (|req_valid);
  assign rsp_hs = (state == S_RESP) && rsp_ready[cur_id];
  assign busy   = (state != S_IDLE);

  // The accept strobe is combinational; masking it with reset_n keeps it
  // quiet while reset is held even if requesters keep req_valid high.
  assign req_ready = (grant && reset_n) ? id_onehot(gnt_id) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= PTR_RST;
      cur_id      <= '0;
      wd_cnt      <= '0;
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      err_timeout <= 1'b0;
      err_id      <= '0;
    end else begin
      // Start pulse, operands and abort strobe are single-cycle by default.
      mult_start  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      err_timeout <= 1'b0;
      case (state)
        // IDLE -> ISSUE: accept, remember the winner, load the launch regs
        S_IDLE: begin
          if (grant) begin
            cur_id     <= gnt_id;
            ptr        <= gnt_id;
            mult_start <= 1'b1;
            mult_a     <= req_a[{gnt_id, 3'b000} +: DATA_W];
            mult_b     <= req_b[{gnt_id, 3'b000} +: DATA_W];
            state      <= S_ISSUE;
          end
        end
        // ISSUE -> WAIT: launch is visible this cycle, arm the watchdog
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        // WAIT -> RESP on done, or -> IDLE after TIMEOUT cycles without it
        S_WAIT: begin
          if (mult_done) begin
            rsp_result <= mult_result;
            rsp_valid  <= id_onehot(cur_id);
            state      <= S_RESP;
          end else if (wd_cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            err_id      <= cur_id;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        // RESP -> IDLE once the granted requester takes the result
        S_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
module tb_mult_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam int IDW     = 2;
  localparam int LAT_RSP = 6;   // grant T -> rsp_valid T+6
  localparam int PERIOD  = 7;   // one op per 7 cycles with rsp_ready=1

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [15:0]          rsp_result;
  logic                 mult_start;
  logic [7:0]           mult_a;
  logic [7:0]           mult_b;
  logic                 mult_done;
  logic [15:0]          mult_result;
  logic                 busy;
  logic                 err_timeout;
  logic [IDW-1:0]       err_id;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mult_rr_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_result(mult_result),
    .busy(busy), .err_timeout(err_timeout), .err_id(err_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 4-cycle multiplier; mult_hang suppresses done.
  logic        mult_hang;
  logic [3:0]  dpipe;
  logic [15:0] rp0, rp1, rp2, rp3;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dpipe <= '0; rp0 <= '0; rp1 <= '0; rp2 <= '0; rp3 <= '0;
    end else begin
      dpipe <= {dpipe[2:0], mult_start & ~mult_hang};
      rp0   <= {8'd0, mult_a} * {8'd0, mult_b};
      rp1   <= rp0; rp2 <= rp1; rp3 <= rp2;
    end
  end
  assign mult_done   = dpipe[3];
  assign mult_result = rp3;

  // Reference round-robin: the set bit at the smallest forward distance
  // past the last grant.
  function automatic int ref_pick(input logic [NUM_REQ-1:0] m, input int last);
    int best, bestd, d;
    best = -1; bestd = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++)
      if (m[i]) begin
        d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
        if (d < bestd) begin bestd = d; best = i; end
      end
    return best;
  endfunction

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '0; mult_hang = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0; rsp_ready = '0; mult_hang = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_result, mult_start, mult_a, mult_b} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0",
                         {req_ready, rsp_valid, rsp_result, mult_start, mult_a, mult_b});
    end
    n_tests++;
    if ({busy, err_timeout, err_id} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0", {busy, err_timeout, err_id});
    end
    @(negedge clk);
    reset_n = 1'b1; req_valid = 4'b1111; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_priority got=%b exp=0001", req_ready);
    end
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    req_valid = 4'b0001; set_op(0, 8'd12, 8'd10); rsp_ready = 4'b1111; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    t0 = cyc;
    @(negedge clk); req_valid = '0; #1;
    n_tests++;
    if ({mult_start, mult_a, mult_b} !== {1'b1, 8'd12, 8'd10}) begin
      n_fail++; $display("FAIL single_start got=%b/%0d/%0d exp=1/12/10", mult_start, mult_a, mult_b);
    end
    for (int k = 0; k < 20 && rsp_valid == '0; k++) begin @(negedge clk); #1; end
    n_tests++;
    if (cyc - t0 !== LAT_RSP) begin
      n_fail++; $display("FAIL single_latency got=%0d exp=%0d", cyc - t0, LAT_RSP);
    end
    n_tests++;
    if ({rsp_valid, rsp_result} !== {4'b0001, 16'd120}) begin
      n_fail++; $display("FAIL single_rsp got=%b/%0d exp=0001/120", rsp_valid, rsp_result);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({busy, rsp_valid} !== 5'b0) begin
      n_fail++; $display("FAIL single_idle got=%b/%b exp=0/0000", busy, rsp_valid);
    end
  endtask

  task automatic test_rr_rotation();
    int gid[$];
    int gcy[$];
    int viol;
    logic [7:0] a[NUM_REQ];
    logic [7:0] b[NUM_REQ];
    viol = 0;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      a[i] = 8'($urandom); b[i] = 8'($urandom); set_op(i, a[i], b[i]);
    end
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (busy && req_ready != '0) viol++;
      if (req_ready != '0) begin
        if (!$onehot(req_ready)) viol++;
        for (int i = 0; i < NUM_REQ; i++)
          if (req_ready[i]) begin gid.push_back(i); gcy.push_back(cyc); end
      end
      if (rsp_valid != '0) begin
        for (int i = 0; i < NUM_REQ; i++)
          if (rsp_valid[i]) begin
            n_tests++;
            if (rsp_result !== {8'd0, a[i]} * {8'd0, b[i]}) begin
              n_fail++; $display("FAIL rr_result id=%0d got=%0d exp=%0d", i, rsp_result,
                                 int'(a[i]) * int'(b[i]));
            end
          end
      end
    end
    n_tests++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL rr_ready_while_busy got=%0d exp=0", viol);
    end
    n_tests++;
    if (gid.size() < 5) begin
      n_fail++; $display("FAIL rr_grant_count got=%0d exp>=5", gid.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if (gid[k] !== k % NUM_REQ) begin
          n_fail++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, gid[k], k % NUM_REQ);
        end
        if (k > 0) begin
          n_tests++;
          if (gcy[k] - gcy[k-1] !== PERIOD) begin
            n_fail++; $display("FAIL rr_spacing k=%0d got=%0d exp=%0d", k, gcy[k] - gcy[k-1], PERIOD);
          end
        end
      end
    end
  endtask

  task automatic test_max_operands();
    do_reset();
    req_valid = 4'b0100; set_op(2, 8'd255, 8'd255); rsp_ready = 4'b1111;
    @(negedge clk); req_valid = '0; #1;
    for (int k = 0; k < 20 && rsp_valid == '0; k++) begin @(negedge clk); #1; end
    n_tests++;
    if ({rsp_valid, rsp_result} !== {4'b0100, 16'hFE01}) begin
      n_fail++; $display("FAIL max_rsp got=%b/%h exp=0100/fe01", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010; set_op(1, 8'd7, 8'd9); rsp_ready = '0; #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_grant got=%b exp=0010", req_ready);
    end
    @(negedge clk); req_valid = '0;
    for (int k = 0; k < 20 && rsp_valid == '0; k++) begin @(negedge clk); #1; end
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clk);
      req_valid = 4'b0001; set_op(0, 8'd3, 8'd4); #1;
      n_tests++;
      if ({rsp_valid, rsp_result, req_ready} !== {4'b0010, 16'd63, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold h=%0d got=%b/%0d/%b exp=0010/63/0000",
                           h, rsp_valid, rsp_result, req_ready);
      end
    end
    @(negedge clk); rsp_ready = 4'b0010; #1;
    n_tests++;
    if ({rsp_valid, req_ready} !== {4'b0010, 4'b0000}) begin
      n_fail++; $display("FAIL bp_handshake got=%b/%b exp=0010/0000", rsp_valid, req_ready);
    end
    @(negedge clk); rsp_ready = '0; #1;
    n_tests++;
    if ({busy, req_ready} !== {1'b0, 4'b0001}) begin
      n_fail++; $display("FAIL bp_next_grant got=%b/%b exp=0/0001", busy, req_ready);
    end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    mult_hang = 1'b1;
    req_valid = 4'b1000; set_op(3, 8'd11, 8'd13); rsp_ready = 4'b1111; #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL to_grant got=%b exp=1000", req_ready);
    end
    t0 = cyc;
    for (int k = 1; k <= TIMEOUT + 4; k++) begin
      @(negedge clk); req_valid = '0; #1;
      n_tests++;
      if (err_timeout !== (cyc - t0 == 2 + TIMEOUT)) begin
        n_fail++; $display("FAIL to_pulse cyc=+%0d got=%b exp=%b", cyc - t0, err_timeout,
                           (cyc - t0 == 2 + TIMEOUT));
      end
      if (rsp_valid !== '0) begin
        n_tests++; n_fail++; $display("FAIL to_no_rsp got=%b exp=0000", rsp_valid);
      end
      if (cyc - t0 == 2 + TIMEOUT) begin
        n_tests++;
        if ({busy, err_id} !== {1'b0, 2'd3}) begin
          n_fail++; $display("FAIL to_err_id got=%b/%0d exp=0/3", busy, err_id);
        end
      end
    end
    mult_hang = 1'b0;
    @(negedge clk); req_valid = 4'b0001; set_op(0, 8'd5, 8'd6); #1;
    @(negedge clk); req_valid = '0; #1;
    for (int k = 0; k < 20 && rsp_valid == '0; k++) begin @(negedge clk); #1; end
    n_tests++;
    if ({rsp_valid, rsp_result, err_id} !== {4'b0001, 16'd30, 2'd3}) begin
      n_fail++; $display("FAIL to_recover got=%b/%0d/%0d exp=0001/30/3", rsp_valid, rsp_result, err_id);
    end
  endtask

  task automatic test_reset_mid_op();
    int errs;
    errs = 0;
    do_reset();
    req_valid = 4'b0001; set_op(0, 8'd9, 8'd9); rsp_ready = 4'b1111;
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0; req_valid = 4'b0011; set_op(1, 8'd2, 8'd2); #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_result, mult_start, mult_a, mult_b,
         busy, err_timeout, err_id} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got=%h exp=0",
                         {req_ready, rsp_valid, rsp_result, mult_start, mult_a, mult_b,
                          busy, err_timeout, err_id});
    end
    @(negedge clk); reset_n = 1'b1; #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_priority got=%b exp=0001", req_ready);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); req_valid = '0; #1;
      if (err_timeout) errs++;
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL midreset_no_err got=%0d exp=0", errs);
    end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] pv;
    logic [7:0] ra[NUM_REQ];
    logic [7:0] rb[NUM_REQ];
    logic [NUM_REQ-1:0] exp_ready, exp_rsp;
    logic [7:0] ea, eb;
    logic [15:0] prod;
    int last, g, t0, age, ng;
    bit inflight;
    do_reset();
    pv = '0; last = NUM_REQ - 1; inflight = 0; g = 0; t0 = 0; ng = 0;
    ea = '0; eb = '0; prod = '0;
    for (int i = 0; i < NUM_REQ; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (!pv[i] && $urandom_range(0, 3) == 0) begin
          pv[i] = 1'b1; ra[i] = 8'($urandom); rb[i] = 8'($urandom);
        end
      req_valid = pv;
      for (int i = 0; i < NUM_REQ; i++) set_op(i, ra[i], rb[i]);
      rsp_ready = 4'($urandom);
      #1;
      exp_ready = '0;
      if (!inflight && pv != '0) begin
        g = ref_pick(pv, last);
        exp_ready[g] = 1'b1;
      end
      age = cyc - t0;
      exp_rsp = '0;
      if (inflight && age >= LAT_RSP) exp_rsp[g] = 1'b1;
      n_tests++;
      if ({req_ready, busy} !== {exp_ready, inflight}) begin
        n_fail++; $display("FAIL rand_ctrl cyc=%0d got=%b/%b exp=%b/%b", cyc, req_ready, busy,
                           exp_ready, inflight);
      end
      n_tests++;
      if (mult_start !== (inflight && age == 1)) begin
        n_fail++; $display("FAIL rand_start cyc=%0d got=%b exp=%b", cyc, mult_start, inflight && age == 1);
      end else if (mult_start && {mult_a, mult_b} !== {ea, eb}) begin
        n_fail++; $display("FAIL rand_operands got=%0d/%0d exp=%0d/%0d", mult_a, mult_b, ea, eb);
      end
      n_tests++;
      if (rsp_valid !== exp_rsp) begin
        n_fail++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp);
      end else if (exp_rsp != '0 && rsp_result !== prod) begin
        n_fail++; $display("FAIL rand_result got=%0d exp=%0d", rsp_result, prod);
      end
      if (inflight && age >= LAT_RSP && rsp_ready[g]) inflight = 0;
      else if (exp_ready != '0) begin
        inflight = 1; t0 = cyc; last = g; ng++;
        ea = ra[g]; eb = rb[g]; prod = 16'(int'(ra[g]) * int'(rb[g]));
        pv[g] = 1'b0;
      end
    end
    n_tests++;
    if (ng < 20) begin
      n_fail++; $display("FAIL rand_activity got=%0d exp>=20", ng);
    end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '0; mult_hang = 1'b0;
    test_reset();
    test_single();
    test_rr_rotation();
    test_max_operands();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
